cordic_frame_packer: RTL and testbench
======================================

CORDIC_FRAME_PACKER -- requirements
Module: cordic_frame_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result queue depth (power of 2, ≥2).
REQ-002 SHALL have parameter HEADER, default 8'h55, frame sync byte.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles between frames (0 allowed).
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port res_valid  in  1  one-cycle strobe: CORDIC result present.
REQ-007 SHALL have port res_cos  in  16  cosine result, sampled with res_valid.
REQ-008 SHALL have port res_sin  in  16  sine result, sampled with res_valid.
REQ-009 SHALL have port trans_start  out  1  one-cycle start pulse to the 6-byte UART transmitter.
REQ-010 SHALL have port frame_data  out  48  frame to the transmitter; byte [7:0] goes on the wire first.
REQ-011 SHALL have port trans_done  in  1  one-cycle pulse from the transmitter: last byte sent.
REQ-012 SHALL have port fifo_count  out  log2(FIFO_DEPTH)+1  queued results.
REQ-013 SHALL have port drop_cnt  out  8  results lost to overflow, saturating.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL store {res_cos,res_sin} in a FIFO on every cycle res_valid=1, unless the FIFO is full.
REQ-016 SHALL accept a push while full if a pop occurs in the same cycle; fifo_count is then unchanged.
REQ-017 SHALL discard the sample on a push while full with no pop, increment drop_cnt, and hold drop_cnt at 255.
REQ-018 SHALL build each frame as: [7:0]=HEADER, [15:8]=cos[15:8], [23:16]=cos[7:0], [31:24]=sin[15:8], [39:32]=sin[7:0], [47:40]=XOR of bytes 0..4.
REQ-019 SHALL use FSM states IDLE, LOAD, START, WAIT, GAP.
REQ-020 IDLE -> LOAD SHALL occur when fifo_count≠0.
REQ-021 In LOAD, SHALL pop one entry and register frame_data; LOAD -> START SHALL occur unconditionally.
REQ-022 In START, SHALL drive trans_start=1 for exactly one cycle with frame_data already valid; START -> WAIT.
REQ-023 SHALL hold frame_data stable from START until WAIT exits.
REQ-024 WAIT -> GAP SHALL occur on the cycle trans_done=1; trans_done in any other state SHALL be ignored.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; with GAP_CYCLES=0, WAIT SHALL go directly to IDLE.
REQ-026 SHALL never assert trans_start between a trans_start and the matching trans_done.
REQ-027 Latency: with an empty FIFO and IDLE state, res_valid in cycle N SHALL produce trans_start high in cycle N+3.
REQ-028 SHALL transmit frames in arrival order, one frame per queued result, none duplicated.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst_n=0, SHALL set: state=IDLE, trans_start=0, frame_data=0, fifo_count=0, drop_cnt=0, busy=0, FIFO pointers=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame and flush the FIFO; after release, the block SHALL wait for new res_valid and SHALL NOT re-send.

Verification
REQ-032 Single result, cos=16'h1234, sin=16'hABCD -> trans_start at N+3, frame_data=48'h15CDAB341255; trans_done 100 cycles later -> busy falls after GAP_CYCLES+1 cycles.
REQ-033 Burst of 5 results while the first frame is in WAIT (FIFO_DEPTH=4) -> first 4 accepted, 5th dropped, drop_cnt=1; frames then sent in order, each trans_start separated by trans_done plus the gap.
REQ-034 Push in the same cycle as the LOAD pop with FIFO full -> push accepted, fifo_count stays 4, drop_cnt unchanged.
REQ-035 trans_done pulsed while IDLE or START -> ignored, no state change.
REQ-036 rst_n pulsed low during WAIT with 2 entries queued -> all outputs zero, no trans_start after release until a new res_valid.
REQ-037 300 res_valid strobes with the transmitter stalled (trans_done never pulsed) -> drop_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/cordic_frame_packer.sv
// cordic_frame_packer: queues CORDIC cos/sin results and hands each one to a
// 6-byte UART transmitter as a HEADER + payload + XOR-check frame.
module cordic_frame_packer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = 8'h55,
  parameter int         GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        res_valid,
  input  logic [15:0]                 res_cos,
  input  logic [15:0]                 res_sin,
  output logic                        trans_start,
  output logic [47:0]                 frame_data,
  input  logic                        trans_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_cnt,
  output logic                        busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int GW  = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] gap_cnt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          start_d;
  logic          busy_d;
  logic [31:0]   head;
  logic [47:0]   frame_nx;
  logic [7:0]    chk;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign full = (fifo_count == DEPTH);
  assign push = res_valid && (!full || pop);
  assign drop = res_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {res_cos, res_sin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    head = mem[rd_ptr];
    chk  = HEADER ^ head[31:24] ^ head[23:16]
         ^ head[15:8] ^ head[7:0];
    frame_nx = {chk,
                head[7:0], head[15:8],
                head[23:16], head[31:24],
                HEADER};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          state_nx = LOAD;
        end
      end
      LOAD:  state_nx = START;
      START: state_nx = WAIT;
      WAIT: begin
        if (trans_done) begin
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registers line up
  // with the state they describe.
  always_comb begin
    pop     = (state == LOAD);
    start_d = (state_nx == START);
    busy_d  = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_start <= 1'b0;
      busy        <= 1'b0;
      frame_data  <= '0;
    end else begin
      trans_start <= start_d;
      busy        <= busy_d;
      if (pop) begin
        frame_data <= frame_nx;
      end
    end
  end

endmodule

// File: tb/tb_cordic_frame_packer.sv
// tb_cordic_frame_packer: random + directed stimulus against a queue-based
// reference model; frames are checked by a separate scoreboard monitor.
module tb_cordic_frame_packer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] HDR   = 8'h55;
  localparam int         GAP   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_cos = '0;
  logic [15:0] res_sin = '0;
  logic        trans_done = 1'b0;
  logic        trans_start;
  logic [47:0] frame_data;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic        busy;

  cordic_frame_packer #(
    .FIFO_DEPTH(DEPTH),
    .HEADER    (HDR),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_cos    (res_cos),
    .res_sin    (res_sin),
    .trans_start(trans_start),
    .frame_data (frame_data),
    .trans_done (trans_done),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] d;
    int          arr;
  } ent_t;

  ent_t        mq[$];
  logic [47:0] exp_frames[$];
  int          exp_start[$];

  int          idle_from = 0;
  bit          tx_busy = 1'b0;
  int          tx_start_c = 0;
  int          tx_done_c = 0;
  logic [47:0] tx_frame = '0;
  int          drop_m = 0;
  int          dmin = 1;
  int          dmax = 8;
  bit          stall = 1'b0;

  int          mon_ec;
  logic [47:0] mon_ef;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] mk(input logic [15:0] c,
                                     input logic [15:0] s);
    logic [7:0]  b[6];
    logic [47:0] f;
    b[0] = HDR;
    b[1] = c[15:8];
    b[2] = c[7:0];
    b[3] = s[15:8];
    b[4] = s[7:0];
    b[5] = 8'h00;
    for (int i = 0; i < 5; i++) b[5] ^= b[i];
    f = '0;
    for (int i = 0; i < 6; i++) f[8*i +: 8] = b[i];
    return f;
  endfunction

  // One clock cycle: check registered state, advance the model, drive inputs.
  task automatic step(input bit pv, input logic [15:0] cs,
                      input logic [15:0] sn, input bit spur_ok);
    bit   pop;
    ent_t e;
    @(negedge clk);
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    pop = !tx_busy && (mq.size() != 0) && (cyc - 1 >= idle_from)
          && (mq[0].arr <= cyc - 2);
    if (pop) begin
      e = mq.pop_front();
      tx_busy = 1'b1;
      tx_start_c = cyc + 1;
      tx_done_c = stall ? -1 : tx_start_c + $urandom_range(dmax, dmin);
      tx_frame = mk(e.d[31:16], e.d[15:0]);
      exp_start.push_back(cyc + 1);
    end
    chk("busy", 64'(busy), 64'(tx_busy || (cyc < idle_from)));
    if (tx_busy && (cyc >= tx_start_c)) begin
      chk("frame_hold", 64'(frame_data), 64'(tx_frame));
    end
    res_valid = pv;
    res_cos = cs;
    res_sin = sn;
    if (pv) begin
      if (mq.size() < DEPTH) begin
        mq.push_back('{d: {cs, sn}, arr: cyc});
        exp_frames.push_back(mk(cs, sn));
      end else if (drop_m < 255) begin
        drop_m++;
      end
    end
    trans_done = 1'b0;
    if (tx_busy && (cyc == tx_done_c)) begin
      trans_done = 1'b1;
      tx_busy = 1'b0;
      idle_from = cyc + GAP + 1;
    end else if (spur_ok && (!tx_busy || (cyc == tx_start_c))
                 && ($urandom_range(0, 5) == 0)) begin
      trans_done = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_trans_start"}, 64'(trans_start), 64'(0));
    chk({tag, "_frame_data"}, 64'(frame_data), 64'(0));
    chk({tag, "_fifo_count"}, 64'(fifo_count), 64'(0));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    res_valid = 1'b0;
    trans_done = 1'b0;
    mq.delete();
    exp_frames.delete();
    exp_start.delete();
    tx_busy = 1'b0;
    drop_m = 0;
    #1;
    chk_zero("rst_async");
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    idle_from = cyc;
  endtask

  task automatic idle(input int n, input bit spur_ok);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, spur_ok);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || tx_busy || cyc <= idle_from + 1)
           && n < 2000) begin
      step(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end
    chk("drain_timeout", 64'(n < 2000), 64'(1));
    chk("drain_starts_left", 64'(exp_start.size()), 64'(0));
    chk("drain_frames_left", 64'(exp_frames.size()), 64'(0));
  endtask

  // Scoreboard monitor: every trans_start must match the next queued frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && trans_start) begin
        if (exp_start.size() == 0 || exp_frames.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got trans_start=1 want 0 (cycle %0d)",
                   cyc);
        end else begin
          mon_ec = exp_start.pop_front();
          mon_ef = exp_frames.pop_front();
          chk("start_cycle", 64'(cyc), 64'(mon_ec));
          chk("frame_data", 64'(frame_data), 64'(mon_ef));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    idle(3, 1'b0);

    // Single result, 100-cycle transmit, latency and exact frame.
    dmin = 100;
    dmax = 100;
    step(1'b1, 16'h1234, 16'hABCD, 1'b0);
    idle(3, 1'b0);
    chk("single_start", 64'(trans_start), 64'(1));
    chk("single_frame", 64'(frame_data), 64'(48'h15CDAB341255));
    drain();

    // Burst of five while the first frame is in WAIT.
    dmin = 60;
    dmax = 60;
    step(1'b1, 16'h0102, 16'h0304, 1'b0);
    idle(5, 1'b1);
    dmin = 3;
    dmax = 10;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), 1'b1);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("burst_drop", 64'(drop_cnt), 64'(1));
    chk("burst_count", 64'(fifo_count), 64'(4));
    drain();

    // Random traffic with spurious trans_done pulses.
    dmin = 1;
    dmax = 12;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), 1'b1);
    end
    // Saturated input: pushes coincide with every LOAD pop while full.
    dmin = 1;
    dmax = 3;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    end
    drain();

    // Reset during WAIT with two entries queued; nothing may be re-sent.
    dmin = 50;
    dmax = 50;
    step(1'b1, 16'hAAAA, 16'h5555, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 16'h1111, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 16'h4444, 1'b0);
    idle(2, 1'b0);
    chk("pre_reset_count", 64'(fifo_count), 64'(2));
    do_reset();
    idle(40, 1'b1);
    dmin = 2;
    dmax = 6;
    step(1'b1, 16'hBEEF, 16'hCAFE, 1'b1);
    drain();

    // Stalled transmitter: drop counter saturates.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    end
    step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("drop_saturated", 64'(drop_cnt), 64'(255));
    chk("stall_count", 64'(fifo_count), 64'(DEPTH));
    stall = 1'b0;
    do_reset();
    idle(5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
